// File: rtl/seq_cla_subtractor.sv
// Multi-cycle W-bit subtractor (a + ~b + 1), one DWL-bit carry-lookahead chunk per clock,
// LSB chunk first, with valid/ready handshakes on operand and result sides.
module seq_cla_subtractor #(
    parameter int DWL    = 4,
    parameter int NCHUNK = 4,
    localparam int W     = DWL * NCHUNK,
    localparam int IDXW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf,
    output logic         zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_r;
    logic [IDXW-1:0] idx_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    diff_r;
    logic            borrow_r;
    logic            ovf_r;
    logic            zero_r;

    int              base_s;
    logic [DWL-1:0]  p_s;
    logic [DWL-1:0]  g_s;
    logic [DWL:0]    c_s;
    logic [DWL-1:0]  sum_s;
    logic [W-1:0]    new_diff_s;
    logic            last_s;

    // Select the current chunk and form propagate/generate against the inverted subtrahend.
    always_comb begin
        base_s = int'(idx_r) * DWL;
        p_s    = a_r[base_s +: DWL] ^ ~b_r[base_s +: DWL];
        g_s    = a_r[base_s +: DWL] & ~b_r[base_s +: DWL];
        last_s = (idx_r == IDXW'(NCHUNK - 1));
    end

    // Lookahead carries: each c[i+1] is a flat sum of G_j & P_(j+1..i) terms plus P_(0..i) & c_in.
    always_comb begin : lookahead
        logic term;
        logic acc;
        term   = 1'b0;
        acc    = 1'b0;
        c_s    = '0;
        c_s[0] = carry_r;
        for (int i = 0; i < DWL; i++) begin
            term = carry_r;
            for (int k = 0; k <= i; k++) begin
                term = term & p_s[k];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p_s[k];
                end
                acc = acc | term;
            end
            c_s[i+1] = acc;
        end
    end

    // Merge this chunk's sum into the running result.
    always_comb begin
        sum_s                    = p_s ^ c_s[DWL-1:0];
        new_diff_s               = diff_r;
        new_diff_s[base_s +: DWL] = sum_s;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            carry_r  <= 1'b1;
            a_r      <= '0;
            b_r      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx_r   <= '0;
                        carry_r <= 1'b1;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    diff_r  <= new_diff_s;
                    carry_r <= c_s[DWL];
                    idx_r   <= idx_r + 1'b1;
                    if (last_s) begin
                        borrow_r <= ~c_s[DWL];
                        ovf_r    <= (a_r[W-1] != b_r[W-1]) && (new_diff_s[W-1] != a_r[W-1]);
                        zero_r   <= (new_diff_s == '0);
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating with rst keeps in_ready low for the whole reset window.
    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign out_valid = (state_r == ST_DONE);
    assign diff      = diff_r;
    assign borrow    = borrow_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Scoreboard bench for seq_cla_subtractor: expected results are queued on operand acceptance
// and compared when the result handshake completes.
module tb_seq_cla_subtractor;

    localparam int DWL    = 4;
    localparam int NCHUNK = 4;
    localparam int W      = DWL * NCHUNK;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           cyc      = 0;
    int           acc_cyc  = 0;
    logic         prev_ov  = 1'b0;
    logic [W-1:0] obs_diff;
    logic         obs_borrow;
    logic         obs_ovf;
    logic         obs_zero;

    seq_cla_subtractor #(.DWL(DWL), .NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        logic [W:0]  t;
        t    = {1'b0, av} - {1'b0, bv};
        e.d  = t[W-1:0];
        e.bo = t[W];
        e.ov = (av[W-1] != bv[W-1]) && (t[W-1] != av[W-1]);
        e.z  = (t[W-1:0] == '0);
        return e;
    endfunction

    // Monitor: push on accept, check latency on out_valid rise, pop and compare on result handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc_cyc = cyc;
            end
            if (out_valid && !prev_ov) begin
                check_eq("latency", cyc - acc_cyc, NCHUNK + 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("sb_diff", diff, e.d);
                    check_eq("sb_borrow", borrow, e.bo);
                    check_eq("sb_ovf", ovf, e.ov);
                    check_eq("sb_zero", zero, e.z);
                end
                obs_diff   = diff;
                obs_borrow = borrow;
                obs_ovf    = ovf;
                obs_zero   = zero;
                n_done++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq({tag, "_ready_to"}, t >= 50, 0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] ed,
                          input logic eb, input logic eo, input logic ez, input string tag);
        int d0;
        int t = 0;
        wait_ready(tag);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        d0 = n_done;
        while (n_done == d0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq({tag, "_done_to"}, t >= 40, 0);
        check_eq({tag, "_diff"}, obs_diff, ed);
        check_eq({tag, "_borrow"}, obs_borrow, eb);
        check_eq({tag, "_ovf"}, obs_ovf, eo);
        check_eq({tag, "_zero"}, obs_zero, ez);
    endtask

    initial begin
        int sent;
        int guard;
        int t;
        logic [W-1:0] hd;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #3;
        check_eq("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready2", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_diff", diff, 0);
        check_eq("rst_flags", {borrow, ovf, zero}, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, "t1");
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, "t2");
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, "t3a");
        run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, "t3b");
        run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, "t_zero0");

        // Back-pressure: result must hold and inputs be ignored while out_ready is low.
        wait_ready("t4");
        out_ready = 1'b0;
        a = 16'h5A5A; b = 16'h5A5A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("t4_valid_to", t >= 20, 0);
        hd = diff;
        check_eq("t4_diff", diff, 16'h0000);
        check_eq("t4_zero", zero, 1);
        check_eq("t4_borrow", borrow, 0);
        for (int i = 0; i < 5; i++) begin
            a = 16'h1111 * 16'(i + 1); b = 16'h0001; in_valid = i[0];
            @(posedge clk); #1;
            check_eq("t4_hold_diff", diff, hd);
            check_eq("t4_hold_valid", out_valid, 1);
            check_eq("t4_hold_in_ready", in_ready, 0);
            check_eq("t4_hold_zero", zero, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_hs_valid", out_valid, 0);
        check_eq("t4_hs_idle", in_ready, 1);
        check_eq("t4_q_empty", exp_q.size(), 0);

        // Reset abort during the second BUSY cycle.
        a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", out_valid, 0);
        check_eq("t5_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("t5_idle_ready", in_ready, 1);
        check_eq("t5_idle_valid", out_valid, 0);
        run_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, "t5");

        // Random traffic with random handshakes; the monitor checks every result.
        sent = 0;
        guard = 0;
        while (sent < 1000 && guard < 40000) begin
            @(posedge clk); #1;
            out_ready = ($urandom % 3) != 0;
            in_valid = 1'b0;
            if (($urandom % 4) != 0) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (($urandom % 8) == 0) b = a;
                in_valid = 1'b1;
                if (in_ready) sent++;
            end
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("rand_sent", sent, 1000);
        check_eq("rand_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
